// File: rtl/serdes_link_sched.sv
// Round-robin byte scheduler feeding a UART-like serializer.
// Each frame carries a start bit, a 2-bit channel id, 8 data bits and a stop bit.
module serdes_link_sched #(
  parameter int BAUD_DIV = 1,
  parameter int NREQ     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        ser_out,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        frame_done
);

  typedef enum logic [2:0] {IDLE, START, ID, DATA, STOP} state_t;

  localparam logic [7:0] BAUD_RELOAD = 8'(BAUD_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  baud_q, baud_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic [1:0]  gid_q, gid_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        ser_q, ser_d;

  logic [1:0]  cand;
  logic [1:0]  win_id;
  logic        win_found;
  logic        grant;
  logic        bit_end;

  // First valid requester at or after the round-robin pointer; 2-bit add wraps 3->0.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign grant     = (state_q == IDLE) && ena && win_found && !rst;
  assign req_ready = grant ? (4'b0001 << win_id) : 4'b0000;
  assign bit_end   = (baud_q == 8'd0);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    gid_d      = gid_q;
    ptr_d      = ptr_q;
    frame_done = 1'b0;

    if (state_q != IDLE) begin
      baud_d = bit_end ? BAUD_RELOAD : baud_q - 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = START;
          baud_d  = BAUD_RELOAD;
          idx_d   = 3'd0;
          byte_d  = req_data[{win_id, 3'b000} +: 8];
          gid_d   = win_id;
          ptr_d   = win_id + 2'd1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = ID;
          idx_d   = 3'd0;
        end
      end
      ID: begin
        if (bit_end) begin
          if (idx_q == 3'd1) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = STOP;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is derived from the next state so the registered output lines up with it.
  always_comb begin
    case (state_d)
      START:   ser_d = 1'b0;
      ID:      ser_d = gid_d[idx_d[0]];
      DATA:    ser_d = byte_d[idx_d];
      default: ser_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= 8'd0;
      idx_q   <= 3'd0;
      byte_q  <= 8'd0;
      gid_q   <= 2'd0;
      ptr_q   <= 2'd0;
      ser_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      ser_q   <= ser_d;
    end
  end

  assign ser_out  = ser_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = gid_q;

endmodule

// File: doc/serdes_link_sched.md
SERDES_LINK_SCHED -- requirements
Module: serdes_link_sched

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 1, meaning clock cycles per serial bit (legal range 1..255).
REQ-002 The block SHALL have parameter NREQ, fixed at 4, meaning the number of byte requesters.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port ena, input, 1 bit: scheduler enable; gates new grants only.
REQ-006 The block SHALL have port req_valid, input, 4 bits: per-requester byte-available flag.
REQ-007 The block SHALL have port req_data, input, 32 bits: requester i byte on bits [8i+7:8i].
REQ-008 The block SHALL have port req_ready, output, 4 bits: one-hot accept strobe; the byte is taken on the edge where valid and ready are both high.
REQ-009 The block SHALL have port ser_out, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a frame is on the line.
REQ-011 The block SHALL have port grant_id, output, 2 bits: channel of the frame currently or last sent.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at end of stop bit.

Function
REQ-013 The block SHALL implement FSM states IDLE, START, ID, DATA, STOP.
REQ-014 In IDLE, with ena=1 and req_valid!=0, the block SHALL select the first valid requester at or after rr_ptr (wrapping 3->0) and assert that bit of req_ready combinationally in the same cycle.
REQ-015 On that edge, the block SHALL capture the byte and channel, set rr_ptr to winner+1 mod 4, set grant_id, and enter START.
REQ-016 req_ready SHALL be 0 in every state other than IDLE, and in IDLE whenever ena=0.
REQ-017 Frame format on ser_out SHALL be: START=0 (1 bit), ID = grant_id LSB first (2 bits), DATA = byte LSB first (8 bits), STOP=1 (1 bit); 12 bits total.
REQ-018 Each bit SHALL be held exactly BAUD_DIV cycles by a baud counter that reloads at every bit boundary; a frame SHALL occupy exactly 12*BAUD_DIV cycles.
REQ-019 ser_out SHALL be registered and SHALL be 1 in IDLE.
REQ-020 busy SHALL be 1 in START, ID, DATA and STOP, and 0 in IDLE.
REQ-021 frame_done SHALL pulse for exactly one cycle, coincident with the last cycle of STOP, after which the FSM returns to IDLE.
REQ-022 Back-to-back frames SHALL be separated by exactly one IDLE cycle (ser_out=1), during which the next grant is made.
REQ-023 Deasserting ena mid-frame SHALL NOT disturb the frame in progress; no grant SHALL occur until ena=1 in IDLE.
REQ-024 A requester that drops req_valid before being granted SHALL lose nothing; there is no latched request state.
REQ-025 Changes to req_data after capture SHALL NOT affect the frame in progress.
REQ-026 With all four requesters continuously valid, grants SHALL rotate 0,1,2,3,0,... (starting from rr_ptr).

Reset
REQ-027 On any clk edge with rst=1, the block SHALL enter IDLE with ser_out=1, busy=0, req_ready=0, grant_id=0, frame_done=0, rr_ptr=0, and baud counter and bit index cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; the captured byte SHALL be discarded and not retransmitted.
REQ-029 While rst=1, req_ready SHALL be 0 regardless of req_valid and ena.

Verification
REQ-030 The bench SHALL cover: BAUD_DIV=1, req_valid=4'b0001, byte 0xA5 -> req_ready[0] high for 1 cycle; ser_out = 0,0,0,1,0,1,0,0,1,0,1,1; frame_done pulses 12 cycles after the grant edge.
REQ-031 The bench SHALL cover: all four requesters valid with bytes 0x11/0x22/0x33/0x44 -> grant_id sequence 0,1,2,3; 13-cycle frame period (12 bits plus 1 idle).
REQ-032 The bench SHALL cover: BAUD_DIV=4, single byte 0xFF -> start bit low for exactly 4 cycles; busy high for exactly 48 cycles.
REQ-033 The bench SHALL cover: ena dropped in the middle of DATA with requester 2 pending -> current frame completes; no grant while ena=0; grant to requester 2 in the first IDLE cycle after ena returns to 1.
REQ-034 The bench SHALL cover: rst pulsed during the ID bits -> next cycle ser_out=1, busy=0, rr_ptr=0; a following request from requester 3 is granted with grant_id=3.
REQ-035 The bench SHALL cover: req_data changed the cycle after capture -> the serialized byte equals the captured value.
